memop_sequencer: RTL and testbench

- Multi-cycle controller for the core's data-memory port in the EX/MEM stage.
- Accepts decoded memory operations: load, store, and AMO, including LR/SC.
- Sequences them over a single valid/ready/rvalid memory bus. AMOs run as a read-modify-write, two bus transactions.
- Stalls the pipeline until the operation completes, and reports misaligned-access exceptions without touching the bus.

---
 rtl/memop_sequencer_if.sv | 29 ++
 rtl/memop_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_memop_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memop_sequencer_if.sv
`default_nettype none
// ============================================================================
// memop_sequencer_if : data-memory bus (valid/ready request, rvalid response)
// Revision 1.0
// ============================================================================
interface memop_sequencer_if #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wen;
    logic [XLEN-1:0]       mem_wdata;
    logic [7:0]            mem_wmask;
    logic                  mem_rvalid;
    logic [XLEN-1:0]       mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memop_sequencer.sv
`default_nettype none
// ============================================================================
// memop_sequencer : EX/MEM load/store/AMO/LR/SC sequencer over one memory bus
// Revision 1.0
// ============================================================================
module memop_sequencer #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_valid,
    input  wire logic                  i_is_new,
    input  wire logic                  i_flush,
    input  wire logic                  i_is_load,
    input  wire logic                  i_is_store,
    input  wire logic                  i_is_amo,
    input  wire logic [2:0]            i_funct3,
    input  wire logic [4:0]            i_funct5,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic [XLEN-1:0]       i_wdata,
    output logic                       o_stall,
    output logic [XLEN-1:0]            o_result,
    output logic                       o_done,
    output logic                       o_exc_valid,
    output logic                       o_exc_store,
    memop_sequencer_if.master          bus
);

    localparam logic [4:0] c_F5_LR   = 5'b00010;
    localparam logic [4:0] c_F5_SC   = 5'b00011;
    localparam logic [4:0] c_F5_SWAP = 5'b00001;
    localparam logic [4:0] c_F5_ADD  = 5'b00000;
    localparam logic [4:0] c_F5_XOR  = 5'b00100;
    localparam logic [4:0] c_F5_AND  = 5'b01100;
    localparam logic [4:0] c_F5_OR   = 5'b01000;
    localparam logic [4:0] c_F5_MIN  = 5'b10000;
    localparam logic [4:0] c_F5_MAX  = 5'b10100;
    localparam logic [4:0] c_F5_MINU = 5'b11000;
    localparam logic [4:0] c_F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_RESP     = 3'd2,
        S_AMO_REQ  = 3'd3,
        S_AMO_RESP = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [XLEN-1:0]         r_wdata;
    logic [2:0]              r_funct3;
    logic [4:0]              r_funct5;
    logic                    r_is_load;
    logic                    r_is_store;
    logic                    r_is_lr;
    logic                    r_is_sc;
    logic                    r_is_rmw;
    logic [XLEN-1:0]         r_old;
    logic [XLEN-1:0]         r_new;
    logic                    r_res_valid;
    logic [ADDR_WIDTH-4:0]   r_res_addr;

    logic                    w_start;
    logic                    w_misaligned;
    logic                    w_in_lr;
    logic                    w_in_sc;
    logic                    w_in_rmw;
    logic                    w_in_loadlike;
    logic                    w_sc_fail;
    logic                    w_capture;
    logic                    w_amo_latch;
    logic                    w_res_set;
    logic                    w_res_clr;
    logic                    w_mem_valid;
    logic [5:0]              w_shamt;
    logic [7:0]              w_size_mask;
    logic [XLEN-1:0]         w_lane;
    logic [XLEN-1:0]         w_load_val;

    // ------------------------------------------------------------------------
    // Input decode (only meaningful while IDLE)
    // ------------------------------------------------------------------------
    assign w_in_lr       = i_is_amo && (i_funct5 == c_F5_LR);
    assign w_in_sc       = i_is_amo && (i_funct5 == c_F5_SC);
    assign w_in_rmw      = i_is_amo && !w_in_lr && !w_in_sc;
    assign w_in_loadlike = w_in_lr || (i_is_load && !i_is_amo);
    assign w_start       = i_valid && i_is_new && !i_flush && (i_is_load || i_is_store || i_is_amo);
    assign w_sc_fail     = w_in_sc && !(r_res_valid && (r_res_addr == i_addr[ADDR_WIDTH-1:3]));

    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'd1:    w_misaligned = i_addr[0];
            2'd2:    w_misaligned = |i_addr[1:0];
            2'd3:    w_misaligned = |i_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Lane extraction and extension of the read response
    // ------------------------------------------------------------------------
    assign w_shamt = {r_addr[2:0], 3'b000};

    always_comb begin
        w_lane = bus.mem_rdata >> w_shamt;
        case (r_funct3)
            3'd0:    w_load_val = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            3'd1:    w_load_val = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'd2:    w_load_val = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            3'd4:    w_load_val = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            3'd5:    w_load_val = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            3'd6:    w_load_val = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            default: w_load_val = w_lane;
        endcase
    end

    always_comb begin
        case (r_funct3[1:0])
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // W variants compare and combine only the low word; upper lanes are masked off on write
    function automatic logic [XLEN-1:0] amo_alu(
        input logic [4:0]      op,
        input logic            is_w,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        logic            lt_s;
        logic            lt_u;
        if (is_w) begin
            lt_s = $signed(a[31:0]) < $signed(b[31:0]);
            lt_u = a[31:0] < b[31:0];
        end else begin
            lt_s = $signed(a) < $signed(b);
            lt_u = a < b;
        end
        case (op)
            c_F5_SWAP: r = b;
            c_F5_ADD:  r = a + b;
            c_F5_XOR:  r = a ^ b;
            c_F5_AND:  r = a & b;
            c_F5_OR:   r = a | b;
            c_F5_MIN:  r = lt_s ? a : b;
            c_F5_MAX:  r = lt_s ? b : a;
            c_F5_MINU: r = lt_u ? a : b;
            c_F5_MAXU: r = lt_u ? b : a;
            default:   r = b;
        endcase
        if (is_w) begin
            r = {{(XLEN-32){1'b0}}, r[31:0]};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Bus request fields come straight from latched operands, so they are
    // stable for as long as mem_ready stays low.
    // ------------------------------------------------------------------------
    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_addr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
    assign bus.mem_wen   = (r_state == S_AMO_REQ) || r_is_store || r_is_sc;
    assign bus.mem_wdata = ((r_state == S_AMO_REQ) ? r_new : r_wdata) << w_shamt;
    assign bus.mem_wmask = w_size_mask << r_addr[2:0];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        o_stall     = 1'b0;
        o_done      = 1'b0;
        o_result    = '0;
        o_exc_valid = 1'b0;
        o_exc_store = 1'b0;
        w_mem_valid = 1'b0;
        w_capture   = 1'b0;
        w_amo_latch = 1'b0;
        w_res_set   = 1'b0;
        w_res_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_misaligned) begin
                        o_done      = 1'b1;
                        o_exc_valid = 1'b1;
                        o_exc_store = !w_in_loadlike;
                    end else if (w_sc_fail) begin
                        // Failed SC retires immediately, so the pipeline need not hold
                        o_done    = 1'b1;
                        o_result  = {{(XLEN-1){1'b0}}, 1'b1};
                        w_res_clr = 1'b1;
                    end else begin
                        o_stall   = 1'b1;
                        w_capture = 1'b1;
                        w_next    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall     = 1'b1;
                w_mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                o_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    if (r_is_rmw) begin
                        w_amo_latch = 1'b1;
                        w_next      = S_AMO_REQ;
                    end else begin
                        o_stall = 1'b0;
                        o_done  = 1'b1;
                        w_next  = S_IDLE;
                        if (r_is_load || r_is_lr) begin
                            o_result = w_load_val;
                        end
                        if (r_is_lr) begin
                            w_res_set = 1'b1;
                        end
                        if (r_is_sc || (r_is_store && r_res_valid &&
                                        (r_res_addr == r_addr[ADDR_WIDTH-1:3]))) begin
                            w_res_clr = 1'b1;
                        end
                    end
                end
            end
            S_AMO_REQ: begin
                o_stall     = 1'b1;
                w_mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_AMO_RESP;
                end
            end
            S_AMO_RESP: begin
                o_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    o_stall  = 1'b0;
                    o_done   = 1'b1;
                    o_result = r_old;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, AMO and reservation registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_funct5    <= '0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_lr     <= 1'b0;
            r_is_sc     <= 1'b0;
            r_is_rmw    <= 1'b0;
            r_old       <= '0;
            r_new       <= '0;
            r_res_valid <= 1'b0;
            r_res_addr  <= '0;
        end else begin
            if (w_capture) begin
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                r_funct3   <= i_funct3;
                r_funct5   <= i_funct5;
                r_is_load  <= i_is_load && !i_is_amo;
                r_is_store <= i_is_store && !i_is_amo;
                r_is_lr    <= w_in_lr;
                r_is_sc    <= w_in_sc;
                r_is_rmw   <= w_in_rmw;
            end
            if (w_amo_latch) begin
                r_old <= w_load_val;
                r_new <= amo_alu(r_funct5, (r_funct3[1:0] == 2'd2), w_load_val, r_wdata);
            end
            if (w_res_clr) begin
                r_res_valid <= 1'b0;
            end else if (w_res_set) begin
                r_res_valid <= 1'b1;
                r_res_addr  <= r_addr[ADDR_WIDTH-1:3];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memop_sequencer.sv
`default_nettype none
// ============================================================================
// tb_memop_sequencer : directed stimulus with result and bus scoreboards
// Revision 1.0
// ============================================================================
module tb_memop_sequencer;

    localparam int XLEN = 64;
    localparam int AW   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             valid, is_new, flush, is_load, is_store, is_amo;
    logic [2:0]       funct3;
    logic [4:0]       funct5;
    logic [AW-1:0]    addr;
    logic [XLEN-1:0]  wdata;
    logic             o_stall, o_done, o_exc_valid, o_exc_store;
    logic [XLEN-1:0]  o_result;

    logic             rdy, inj_rv, no_resp, r_rv;
    logic [XLEN-1:0]  cfg_rdata, r_rd;

    memop_sequencer_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

    assign bus.mem_ready  = rdy;
    assign bus.mem_rvalid = r_rv | inj_rv;
    assign bus.mem_rdata  = r_rd;

    memop_sequencer #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (valid),
        .i_is_new    (is_new),
        .i_flush     (flush),
        .i_is_load   (is_load),
        .i_is_store  (is_store),
        .i_is_amo    (is_amo),
        .i_funct3    (funct3),
        .i_funct5    (funct5),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_stall     (o_stall),
        .o_result    (o_result),
        .o_done      (o_done),
        .o_exc_valid (o_exc_valid),
        .o_exc_store (o_exc_store),
        .bus         (bus)
    );

    // Memory model: one response the cycle after each accepted request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rv <= 1'b0;
        else        r_rv <= bus.mem_valid && bus.mem_ready && !no_resp;
    end
    always @(posedge clk) r_rd <= cfg_rdata;

    typedef struct { logic [63:0] result; logic exc; logic exc_st; } res_t;
    typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; logic [7:0] wmask; } req_t;
    res_t res_q[$];
    req_t bus_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_res(input logic [63:0] r, input logic e, input logic es);
        res_t t;
        t.result = r; t.exc = e; t.exc_st = es;
        res_q.push_back(t);
    endtask

    task automatic exp_bus(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
        req_t t;
        t.addr = a; t.wen = w; t.wdata = d; t.wmask = m;
        bus_q.push_back(t);
    endtask

    // Result monitor
    always @(negedge clk) begin : mon_res
        res_t e;
        if (rst_n && o_done) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got result %h with no expectation", o_result);
            end else begin
                e = res_q.pop_front();
                chk("result", o_result, e.result);
                chk("exc_valid", {63'd0, o_exc_valid}, {63'd0, e.exc});
                if (e.exc) chk("exc_store", {63'd0, o_exc_store}, {63'd0, e.exc_st});
            end
        end
    end

    // Bus monitor: compares every presented request cycle, pops on acceptance
    always @(negedge clk) begin : mon_bus
        req_t e;
        if (rst_n && bus.mem_valid) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_request: got addr %h wen %0d", bus.mem_addr, bus.mem_wen);
            end else begin
                e = bus_q[0];
                chk("mem_addr", bus.mem_addr, e.addr);
                chk("mem_wen", {63'd0, bus.mem_wen}, {63'd0, e.wen});
                if (e.wen) begin
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
                    chk("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, e.wmask});
                end
                if (bus.mem_ready) void'(bus_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic ld, input logic st, input logic am, input logic [2:0] f3,
                          input logic [4:0] f5, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input bit chk_stall);
        bit got;
        bit stall_ok;
        logic stall_done;
        cfg_rdata = rd;
        @(posedge clk); #1;
        valid = 1'b1; is_new = 1'b1; flush = 1'b0;
        is_load = ld; is_store = st; is_amo = am;
        funct3 = f3; funct5 = f5; addr = a; wdata = wd;
        got = 1'b0; stall_ok = 1'b1; stall_done = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1'b1;
                stall_done = o_stall;
            end else begin
                if (!o_stall) stall_ok = 1'b0;
                @(posedge clk); #1;
                valid = 1'b0; is_new = 1'b0;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0; is_new = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles for addr %h", a);
        end
        if (chk_stall) begin
            chk("stall_held", {63'd0, stall_ok}, 64'd1);
            chk("stall_at_done", {63'd0, stall_done}, 64'd0);
        end
        chk("bus_queue_left", 64'(bus_q.size()), 64'd0);
        chk("res_queue_left", 64'(res_q.size()), 64'd0);
    endtask

    initial begin
        valid = 0; is_new = 0; flush = 0; is_load = 0; is_store = 0; is_amo = 0;
        funct3 = 0; funct5 = 0; addr = 0; wdata = 0;
        rdy = 1; inj_rv = 0; no_resp = 0; cfg_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {63'd0, o_stall}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);
        chk("rst_exc", {63'd0, o_exc_valid}, 64'd0);
        chk("rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("rst_result", o_result, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // LW, upper word negative
        exp_bus(64'h1000, 0, 0, 0); exp_res(64'hFFFF_FFFF_8000_0000, 0, 0);
        run_op(1, 0, 0, 3'd2, 5'd0, 64'h1004, 0, 64'h8000_0000_0000_0000, 1);
        // SB lane 3
        exp_bus(64'h2000, 1, 64'h0000_0000_AB00_0000, 8'h08); exp_res(0, 0, 0);
        run_op(0, 1, 0, 3'd0, 5'd0, 64'h2003, 64'hAB, 0, 1);
        // AMOADD.D: read 10, write 15, return 10
        exp_bus(64'h3000, 0, 0, 0); exp_bus(64'h3000, 1, 64'd15, 8'hFF); exp_res(64'd10, 0, 0);
        run_op(0, 0, 1, 3'd3, 5'b00000, 64'h3000, 64'd5, 64'd10, 1);
        // LR.W then SC.W to same address
        exp_bus(64'h4000, 0, 0, 0); exp_res(64'h1234_5678, 0, 0);
        run_op(1, 0, 1, 3'd2, 5'b00010, 64'h4000, 0, 64'h1234_5678, 1);
        exp_bus(64'h4000, 1, 64'h99, 8'h0F); exp_res(0, 0, 0);
        run_op(0, 0, 1, 3'd2, 5'b00011, 64'h4000, 64'h99, 0, 1);
        // SC without reservation: no bus access
        exp_res(64'd1, 0, 0);
        run_op(0, 0, 1, 3'd2, 5'b00011, 64'h4008, 64'h77, 0, 0);
        // Misaligned LH and AMOSWAP.W
        exp_res(0, 1, 0);
        run_op(1, 0, 0, 3'd1, 5'd0, 64'h5001, 0, 0, 1);
        exp_res(0, 1, 1);
        run_op(0, 0, 1, 3'd2, 5'b00001, 64'h5002, 64'h1, 0, 1);
        // LBU and LB of top byte
        exp_bus(64'h6000, 0, 0, 0); exp_res(64'hF0, 0, 0);
        run_op(1, 0, 0, 3'd4, 5'd0, 64'h6007, 0, 64'hF000_0000_0000_0000, 1);
        exp_bus(64'h6000, 0, 0, 0); exp_res(64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
        run_op(1, 0, 0, 3'd0, 5'd0, 64'h6007, 0, 64'hF000_0000_0000_0000, 1);
        // AMOMINU.W / AMOMIN.W on upper word holding -2, rs2 = 5
        exp_bus(64'h7000, 0, 0, 0); exp_bus(64'h7000, 1, 64'h0000_0005_0000_0000, 8'hF0);
        exp_res(64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(0, 0, 1, 3'd2, 5'b11000, 64'h7004, 64'd5, 64'hFFFF_FFFE_0000_0000, 1);
        exp_bus(64'h7000, 0, 0, 0); exp_bus(64'h7000, 1, 64'hFFFF_FFFE_0000_0000, 8'hF0);
        exp_res(64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        run_op(0, 0, 1, 3'd2, 5'b10000, 64'h7004, 64'd5, 64'hFFFF_FFFE_0000_0000, 1);
        // LR.D, intervening SD to reserved doubleword, SC.D fails
        exp_bus(64'h8000, 0, 0, 0); exp_res(64'h1122_3344_5566_7788, 0, 0);
        run_op(1, 0, 1, 3'd3, 5'b00010, 64'h8000, 0, 64'h1122_3344_5566_7788, 1);
        exp_bus(64'h8000, 1, 64'hDEAD, 8'hFF); exp_res(0, 0, 0);
        run_op(0, 1, 0, 3'd3, 5'd0, 64'h8000, 64'hDEAD, 0, 1);
        exp_res(64'd1, 0, 0);
        run_op(0, 0, 1, 3'd3, 5'b00011, 64'h8000, 64'h5, 0, 0);
        // LD with mem_ready held low for several REQ cycles
        rdy = 1'b0;
        fork
            begin repeat (5) @(posedge clk); #1; rdy = 1'b1; end
        join_none
        exp_bus(64'h9000, 0, 0, 0); exp_res(64'h55, 0, 0);
        run_op(1, 0, 0, 3'd3, 5'd0, 64'h9000, 0, 64'h55, 1);

        // Flushed start does nothing
        @(posedge clk); #1;
        valid = 1; is_new = 1; flush = 1; is_load = 1; is_store = 0; is_amo = 0;
        funct3 = 3'd3; addr = 64'hB000;
        @(negedge clk);
        chk("flush_stall", {63'd0, o_stall}, 64'd0);
        chk("flush_done", {63'd0, o_done}, 64'd0);
        @(posedge clk); #1;
        valid = 0; is_new = 0; flush = 0;

        // Reset mid-RESP, then a late rvalid must not complete anything
        no_resp = 1'b1;
        exp_bus(64'hA000, 0, 0, 0);
        @(posedge clk); #1;
        valid = 1; is_new = 1; is_load = 1; is_store = 0; is_amo = 0; funct3 = 3'd3; addr = 64'hA000;
        @(posedge clk); #1;
        valid = 0; is_new = 0;
        @(posedge clk);
        @(negedge clk);
        chk("resp_stall", {63'd0, o_stall}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {63'd0, o_stall}, 64'd0);
        chk("mid_rst_done", {63'd0, o_done}, 64'd0);
        chk("mid_rst_exc", {63'd0, o_exc_valid}, 64'd0);
        chk("mid_rst_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
        chk("mid_rst_result", o_result, 64'd0);
        @(negedge clk); rst_n = 1'b1; no_resp = 1'b0;
        @(posedge clk); #1; inj_rv = 1'b1;
        @(negedge clk);
        chk("late_rvalid_done", {63'd0, o_done}, 64'd0);
        @(posedge clk); #1; inj_rv = 1'b0;
        repeat (2) @(posedge clk);
        chk("final_bus_queue", 64'(bus_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
